// File: rtl/muldiv_seq.sv
// Sequential multiply/divide engine: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and divide-by-zero handling.
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;
  logic               done_q, done_d;

  logic               neg1, neg2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_sh;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] step_nxt;
  logic               flip;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fin1, fin2;

  // Even ops are signed; negating -2^(W-1) yields its unsigned magnitude.
  always_comb begin
    neg1 = Operand1[WIDTH-1] & ~MCycleOp[0];
    neg2 = Operand2[WIDTH-1] & ~MCycleOp[0];
    abs1 = neg1 ? -Operand1 : Operand1;
    abs2 = neg2 ? -Operand2 : Operand2;
  end

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    div_ok  = div_sh >= {1'b0, mcand_q};
    div_rem = div_ok ? (div_sh[WIDTH-1:0] - mcand_q)
                     : div_sh[WIDTH-1:0];
    div_nxt = {div_rem, acc_q[WIDTH-2:0], div_ok};
    step_nxt = op_q[1] ? div_nxt : mul_nxt;
  end

  always_comb begin
    flip = ~op_q[0] & (s1_q ^ s2_q);
    prod = flip ? -step_nxt : step_nxt;
    quo  = step_nxt[WIDTH-1:0];
    rem  = step_nxt[2*WIDTH-1:WIDTH];
    if (op_q[1]) begin
      // Zero divisor leaves |dividend| as remainder; re-signing restores it.
      fin1 = (mcand_q == '0) ? '1 : (flip ? -quo : quo);
      fin2 = (~op_q[0] & s1_q) ? -rem : rem;
    end else begin
      fin1 = prod[WIDTH-1:0];
      fin2 = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          op_d    = MCycleOp;
          s1_d    = neg1;
          s2_d    = neg2;
          acc_d   = {{WIDTH{1'b0}}, MCycleOp[1] ? abs1 : abs2};
          mcand_d = MCycleOp[1] ? abs2 : abs1;
          cnt_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d = step_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res1_d  = fin1;
          res2_d  = fin2;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      done_q  <= done_d;
    end
  end

  // Combinational so the PC stalls in the cycle the request appears.
  assign Busy = ~RESET & (((state_q == IDLE) & Start) | (state_q == COMPUTE));
  assign Done    = done_q;
  assign Result1 = res1_q;
  assign Result2 = res2_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases, random ops against
// an arithmetic model, timing, mid-op changes, back-to-back and reset abort.
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result1, Result2;
  logic        Busy, Done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  muldiv_seq #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  // Returns {Result2, Result1} computed with plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int          sa, sb;
    longint      p;
    logic [63:0] u;
    sa = a;
    sb = b;
    model = '0;
    case (op)
      2'd0: begin p = longint'(sa) * longint'(sb); model = p; end
      2'd1: begin u = {32'b0, a} * {32'b0, b}; model = u; end
      2'd2: begin
        if (b == 0) model = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          model = {32'h0, 32'h80000000};
        else model = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) model = {a, 32'hFFFFFFFF};
        else model = {a % b, a / b};
      end
    endcase
  endfunction

  // Starts one op in a fresh cycle (cycle 0) and waits for Done.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int chg, input bit hold,
                       output logic [31:0] r1, output logic [31:0] r2,
                       output int lat, output int busy_n);
    @(posedge CLK); #2;
    MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
    #1;
    busy_n = Busy ? 1 : 0;
    lat = -1;
    r1 = 'x; r2 = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #2;
      if (c == chg) begin
        Operand1 = $urandom; Operand2 = $urandom; MCycleOp = ~MCycleOp;
      end
      if (Busy) busy_n++;
      if (Done) begin
        lat = c; r1 = Result1; r2 = Result2;
        if (!hold) Start = 1'b0;
        break;
      end
    end
    if (lat < 0) Start = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; Start = 1'b1; MCycleOp = 2'd1;
    Operand1 = 32'd5; Operand2 = 32'd9;
    repeat (2) @(posedge CLK);
    #2;
    tests_run++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", Busy, Done);
    end
    tests_run++;
    if (Result1 !== 32'h0 || Result2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_res: r1=%h r2=%h required 0 0", Result1, Result2);
    end
    RESET = 1'b0; Start = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [9] = '{1, 0, 0, 2, 3, 2, 3, 2, 2};
    logic [31:0] as  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000,
                             32'hFFFFFFF9, 32'd100, 32'h80000000,
                             32'd100, 32'd100, 32'hFFFFFF9C};
    logic [31:0] bs  [9] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2,
                             32'd7, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] e1  [9] = '{32'h1, 32'hFFFFFFEB, 32'h0, 32'hFFFFFFFD,
                             32'd14, 32'h80000000, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e2  [9] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000,
                             32'hFFFFFFFF, 32'd2, 32'h0, 32'd100,
                             32'd100, 32'hFFFFFF9C};
    logic [31:0] r1, r2;
    int lat, bn;
    for (int i = 0; i < 9; i++) begin
      do_op(ops[i], as[i], bs[i], 0, 1'b0, r1, r2, lat, bn);
      tests_run++;
      if (r1 !== e1[i] || r2 !== e2[i]) begin
        tests_failed++;
        $display("FAIL directed[%0d]: got r1=%h r2=%h required %h %h",
                 i, r1, r2, e1[i], e2[i]);
      end
      tests_run++;
      if (lat !== 33 || bn !== 33) begin
        tests_failed++;
        $display("FAIL timing[%0d]: done cycle %0d busy cycles %0d required 33 33",
                 i, lat, bn);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r1, r2;
    logic [1:0]  op;
    logic [63:0] exp;
    int lat, bn;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: a = 32'h80000000;
        2: b = 32'($urandom_range(1, 9));
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      exp = model(op, a, b);
      do_op(op, a, b, 0, 1'b0, r1, r2, lat, bn);
      tests_run++;
      if ({r2, r1} !== exp || lat !== 33) begin
        tests_failed++;
        $display("FAIL random op=%0d a=%h b=%h: got %h_%h lat %0d required %h lat 33",
                 op, a, b, r2, r1, lat, exp);
      end
    end
  endtask

  task automatic test_operand_change();
    logic [31:0] r1, r2;
    logic [63:0] exp;
    int lat, bn;
    for (int op = 0; op < 4; op++) begin
      exp = model(2'(op), 32'hFFFFF123, 32'h00000ABC);
      do_op(2'(op), 32'hFFFFF123, 32'h00000ABC, 5, 1'b0, r1, r2, lat, bn);
      tests_run++;
      if ({r2, r1} !== exp) begin
        tests_failed++;
        $display("FAIL op_change op=%0d: got %h_%h required %h", op, r2, r1, exp);
      end
    end
  endtask

  task automatic test_start_held();
    logic [31:0] r1, r2;
    int lat, bn, extra;
    do_op(2'd3, 32'd1000, 32'd3, 0, 1'b1, r1, r2, lat, bn);
    @(posedge CLK); #1;
    Start = 1'b0;
    #1;
    extra = 0;
    if (Busy) extra++;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #2;
      if (Done || Busy) extra++;
    end
    tests_run++;
    if (extra !== 0 || r1 !== 32'd333 || r2 !== 32'd1) begin
      tests_failed++;
      $display("FAIL start_held: extra activity %0d r1=%0d r2=%0d required 0 333 1",
               extra, r1, r2);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2, q1, q2;
    int l1, l2, bn;
    do_op(2'd1, 32'd12345, 32'd678, 0, 1'b0, r1, r2, l1, bn);
    do_op(2'd2, 32'hFFFF0000, 32'd7, 0, 1'b0, q1, q2, l2, bn);
    tests_run++;
    if (l1 + 1 + l2 !== 67) begin
      tests_failed++;
      $display("FAIL back_to_back_timing: second done cycle %0d required 67",
               l1 + 1 + l2);
    end
    tests_run++;
    if ({r2, r1} !== 64'd8369910 || {q2, q1} !== model(2'd2, 32'hFFFF0000, 32'd7)) begin
      tests_failed++;
      $display("FAIL back_to_back_vals: got %h_%h %h_%h", r2, r1, q2, q1);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r1, r2;
    int lat, bn, dn;
    @(posedge CLK); #2;
    MCycleOp = 2'd1; Operand1 = 32'hDEADBEEF; Operand2 = 32'h1234567;
    Start = 1'b1;
    repeat (10) begin @(posedge CLK); #2; end
    RESET = 1'b1;
    #1;
    tests_run++;
    if (Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy_in_reset: busy=%b required 0", Busy);
    end
    @(posedge CLK); #2;
    tests_run++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result1 !== 32'h0 || Result2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL abort_state: busy=%b done=%b r1=%h r2=%h required 0 0 0 0",
               Busy, Done, Result1, Result2);
    end
    RESET = 1'b0; Start = 1'b0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK); #2;
      if (Done) dn++;
    end
    tests_run++;
    if (dn !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: saw %0d done pulses required 0", dn);
    end
    do_op(2'd1, 32'd6, 32'd7, 0, 1'b0, r1, r2, lat, bn);
    tests_run++;
    if (r1 !== 32'd42 || r2 !== 32'd0 || lat !== 33) begin
      tests_failed++;
      $display("FAIL after_abort: r1=%0d r2=%0d lat %0d required 42 0 33",
               r1, r2, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_operand_change();
    test_start_held();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
